// File: rtl/ps2_scancode_assembler.sv
// Assembles PS/2 Set-2 bytes into 9-bit key events with make/brakee pulses.
// Handles E0/F0 prefixes, the E1 Pause run, control bytes, prefix timeouts and repeat suppression.
module ps2_scancode_assembler #(
  parameter int unsigned TIMEOUT_CYCLES  = 250000,
  parameter bit          SUPPRESS_REPEAT = 1'b1,
  parameter logic [8:0]  PAUSE_CODE      = 9'h0E1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din,
  input  logic       dinNew,
  output logic [8:0] keyCode,
  output logic       make,
  output logic       brakee,
  output logic       seqError
);

  localparam int unsigned   CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_PAUSE} state_t;
  typedef enum logic [2:0] {EV_NONE, EV_MAKE, EV_BREAK, EV_PAUSE, EV_ERR} event_t;

  state_t        state, state_n;
  logic [2:0]    skip, skip_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0]    held, held_n;
  logic [8:0]    code;
  event_t        ev;
  logic          is_ctrl, is_prefix, byte_in, timeout, fake_shift;
  logic          make_n, brakee_n, err_n;
  logic [8:0]    key_n;

  assign is_ctrl   = din inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  assign is_prefix = din inside {8'hE0, 8'hF0, 8'hE1};
  // Control bytes are only data while skipping the Pause run.
  assign byte_in   = dinNew && (state == S_PAUSE || !is_ctrl);
  assign timeout   = !byte_in && state != S_IDLE && cnt == CNT_LAST;

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state    <= S_IDLE;
      skip     <= '0;
      cnt      <= '0;
      held     <= '0;
      keyCode  <= '0;
      make     <= 1'b0;
      brakee   <= 1'b0;
      seqError <= 1'b0;
    end else begin
      state    <= state_n;
      skip     <= skip_n;
      cnt      <= cnt_n;
      held     <= held_n;
      keyCode  <= key_n;
      make     <= make_n;
      brakee   <= brakee_n;
      seqError <= err_n;
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_n = state;
    skip_n  = skip;
    ev      = EV_NONE;
    code    = {1'b0, din};
    if (byte_in) begin
      unique case (state)
        S_IDLE: begin
          if (din == 8'hE0)      state_n = S_EXT;
          else if (din == 8'hF0) state_n = S_BRK;
          else if (din == 8'hE1) begin
            state_n = S_PAUSE;
            skip_n  = 3'd7;
          end else ev = EV_MAKE;
        end
        S_EXT: begin
          code = {1'b1, din};
          if (din == 8'hF0) state_n = S_EXTBRK;
          else begin
            state_n = S_IDLE;
            ev      = is_prefix ? EV_ERR : EV_MAKE;
          end
        end
        S_BRK, S_EXTBRK: begin
          code    = {state == S_EXTBRK, din};
          state_n = S_IDLE;
          ev      = is_prefix ? EV_ERR : EV_BREAK;
        end
        S_PAUSE: begin
          skip_n = skip - 3'd1;
          if (skip == 3'd1) begin
            state_n = S_IDLE;
            ev      = EV_PAUSE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (timeout) begin
      state_n = S_IDLE;
      ev      = EV_ERR;
    end
    // Counter measures the gap since the last accepted byte while a prefix is pending.
    if (byte_in || state_n == S_IDLE) cnt_n = '0;
    else                              cnt_n = cnt + CW'(1);
  end

  assign fake_shift = (code == 9'h112) || (code == 9'h159);

  always_comb begin
    make_n   = 1'b0;
    brakee_n = 1'b0;
    err_n    = 1'b0;
    key_n    = keyCode;
    held_n   = held;
    unique case (ev)
      EV_MAKE: begin
        if (!fake_shift && !(SUPPRESS_REPEAT && code == held)) begin
          make_n = 1'b1;
          key_n  = code;
          held_n = code;
        end
      end
      EV_BREAK: begin
        if (!fake_shift) begin
          brakee_n = 1'b1;
          key_n    = code;
          if (code == held) held_n = '0;
        end
      end
      EV_PAUSE: begin
        make_n = 1'b1;
        key_n  = PAUSE_CODE;
      end
      EV_ERR:  err_n = 1'b1;
      default: ;
    endcase
  end

endmodule
